wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Consumer end of the pipeline-to-writeback registers.
- Takes up to N_SRC completed results (ALU, mem, M5 multiply paths) per cycle from their final stage registers.
- Grants one per cycle round-robin and drives the single ROB write port through a registered output stage.
- Back-pressures losing producers with per-source stall, which their stage registers honour by holding while valid.

Parameters:
N_SRC, 3, number of producer pipelines
WORD_SIZE, `WORD_SIZE (32), result/pc width
INSTR_TYPE_SZ, `INSTR_TYPE_SZ, instruction type field width
ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH, ROB tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
flush  in  1  synchronous pipeline flush, active-high
src_valid  in  N_SRC  per-source result valid
src_instr_type  in  N_SRC*INSTR_TYPE_SZ  packed, source i at slice i
src_pc  in  N_SRC*WORD_SIZE  packed pcs
src_result  in  N_SRC*WORD_SIZE  packed results
src_rob_id  in  N_SRC*ROB_ENTRY_WIDTH  packed ROB tags
src_stall  out  N_SRC  stall to source i; combinational
rob_ready  in  1  ROB accepts the write this cycle
rob_wr_en  out  1  registered write valid
rob_wr_type  out  INSTR_TYPE_SZ  registered
rob_wr_pc  out  WORD_SIZE  registered
rob_wr_result  out  WORD_SIZE  registered
rob_wr_id  out  ROB_ENTRY_WIDTH  registered

Behaviour:
- Reset (reset==0 at posedge): rob_wr_en=0, data outputs=0, rr_ptr=0. src_stall is combinational and is 0 while reset==0.
- Output stage is free when rob_wr_en==0 or rob_ready==1.
- Arbitration, only when the stage is free:
  - Search src_valid starting at index rr_ptr, wrapping modulo N_SRC.
  - The first valid source wins (grant one-hot).
  - At the posedge: load the winner's fields, set rob_wr_en=1, rr_ptr <= (winner+1) mod N_SRC.
  - No valid source: rob_wr_en <= 0, rr_ptr unchanged.
- Stage not free (rob_wr_en==1, rob_ready==0): all outputs hold, no grant, rr_ptr unchanged.
- src_stall[i] = src_valid[i] & ~grant[i]. An invalid source is never stalled.
- Latency: a granted source appears on rob_wr_* one cycle after grant. Throughput is 1 result/cycle while rob_ready==1.
- Fairness: each continuously valid source is granted within N_SRC consecutive grants.
- Flush (flush==1, reset==1):
  - rob_wr_en <= 0, no grant, src_stall=0 (producers are flushed in the same cycle).
  - rr_ptr unchanged.
  - reset has priority over flush.
- Same cycle that the ROB accepts the current entry (rob_ready==1): a new grant loads without a bubble.
- rr_ptr wraps N_SRC-1 -> 0. N_SRC==1 degenerates to a registered pass-through with stall = valid & ~free.

Optional Feature:
- WB_BYPASS_EN: adds outputs bypass_valid (1), bypass_rob_id (ROB_ENTRY_WIDTH) and bypass_result (WORD_SIZE).
  - They present the granted source combinationally in the grant cycle, one cycle before rob_wr_*, for operand forwarding to issue.
  - bypass_valid=0 when there is no grant, during flush, and during reset.
- Without the macro these ports do not exist and forwarding comes only from ROB contents.

Decomposition:
- Shared package/defines: WORD_SIZE, INSTR_TYPE_SZ, ROB_ENTRY_WIDTH, N_SRC default, and a wb_entry struct (type, pc, result, rob_id).
- One sub-module: rr_arbiter (parameter N; inputs req and ptr; output one-hot grant and encoded index). It is purely combinational; the pointer register lives in wb_arbiter.

Test Plan:
1. Reset: hold reset=0 two cycles with src_valid=3'b111 -> rob_wr_en=0, src_stall=000; release -> src0 (rob_id 1) is written next cycle and src_stall=110 in the grant cycle.
2. All three valid continuously (rob_ids 1,2,3), rob_ready=1 -> writes ordered 1,2,3,1..., one per cycle, no bubbles, each source stalled in 2 of every 3 cycles.
3. rob_ready=0 for 3 cycles with rob_wr_id=5 held -> outputs stable at id 5, src_stall equals src_valid, rr_ptr frozen. When ready rises -> the next grant loads in the same cycle.
4. Only src2 valid, result 0xDEADBEEF, pc 0x40 -> rob_wr_result=0xDEADBEEF, rob_wr_pc=0x40 one cycle later, src_stall=000.
5. flush asserted while rob_wr_en=1 and src1 is valid -> next cycle rob_wr_en=0, src_stall=000 during flush, rr_ptr unchanged.
6. With WB_BYPASS_EN, src1 granted with rob_id 7 and result 0x12 -> bypass_valid=1, id 7, 0x12 in the grant cycle; rob_wr_* match one cycle later.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and the writeback entry type for the
// pipeline-to-ROB writeback arbiter.
// Widths come from the global defines when they are provided, and fall back to
// local defaults otherwise.
// Contents:
//   WORD_SIZE        result/pc width
//   INSTR_TYPE_SZ    instruction type field width
//   ROB_ENTRY_WIDTH  ROB tag width
//   N_SRC_DEF        default number of producer pipelines
//   wb_entry_t       one writeback record (type, pc, result, rob_id)
//   idx_w()          index width for an N-way selector (min 1)
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

package wb_arbiter_pkg;
   localparam int WORD_SIZE       = `WORD_SIZE;
   localparam int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ;
   localparam int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH;
   localparam int N_SRC_DEF       = 3;

   typedef struct packed {
      logic [INSTR_TYPE_SZ-1:0]   instr_type;
      logic [WORD_SIZE-1:0]       pc;
      logic [WORD_SIZE-1:0]       result;
      logic [ROB_ENTRY_WIDTH-1:0] rob_id;
   } wb_entry_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle between the producer stage registers, the writeback
// arbiter and the ROB write port.
// Each per-source field is a packed array with source i at index i.
// Signals:
//   src_valid, src_instr_type, src_pc, src_result, src_rob_id  producer -> arbiter
//   src_stall                                                  arbiter -> producer
//   rob_ready                                                  ROB -> arbiter
//   rob_wr_en, rob_wr_type, rob_wr_pc, rob_wr_result, rob_wr_id arbiter -> ROB
// Modports:
//   slave   the arbiter's view
//   master  the environment's view (producers + ROB)
interface wb_arbiter_if import wb_arbiter_pkg::*; #(
   parameter int N_SRC = N_SRC_DEF
) ();
   logic [N_SRC-1:0]                      src_valid;
   logic [N_SRC-1:0][INSTR_TYPE_SZ-1:0]   src_instr_type;
   logic [N_SRC-1:0][WORD_SIZE-1:0]       src_pc;
   logic [N_SRC-1:0][WORD_SIZE-1:0]       src_result;
   logic [N_SRC-1:0][ROB_ENTRY_WIDTH-1:0] src_rob_id;
   logic [N_SRC-1:0]                      src_stall;
   logic                                  rob_ready;
   logic                                  rob_wr_en;
   logic [INSTR_TYPE_SZ-1:0]              rob_wr_type;
   logic [WORD_SIZE-1:0]                  rob_wr_pc;
   logic [WORD_SIZE-1:0]                  rob_wr_result;
   logic [ROB_ENTRY_WIDTH-1:0]            rob_wr_id;

   modport slave (
      input  src_valid, src_instr_type, src_pc, src_result, src_rob_id, rob_ready,
      output src_stall, rob_wr_en, rob_wr_type, rob_wr_pc, rob_wr_result, rob_wr_id
   );

   modport master (
      output src_valid, src_instr_type, src_pc, src_result, src_rob_id, rob_ready,
      input  src_stall, rob_wr_en, rob_wr_type, rob_wr_pc, rob_wr_result, rob_wr_id
   );
endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// It scans req starting at index ptr, wrapping modulo N, and reports the first
// set request. The pointer register belongs to the caller.
// Ports:
//   req    in   N   request vector
//   ptr    in   IW  index at which the scan starts (must be < N)
//   grant  out  N   one-hot winner (all zero when req is empty)
//   idx    out  IW  encoded winner (0 when req is empty)
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);
   always_comb begin
      logic          found;
      logic [IW-1:0] slot;
      int            j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      slot  = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j    = (int'(ptr) + k) % N;
         slot = IW'(j);
         if (!found && req[slot]) begin
            found       = 1'b1;
            grant[slot] = 1'b1;
            idx         = slot;
         end
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter at the end of the ALU, memory and multiply
// pipelines.
// Each cycle it grants one valid producer in round-robin order, and registers
// the winner's result into the single ROB write port. Valid producers that do
// not win are stalled, and their stage registers hold until they are granted.
// Ports:
//   clk    in  clock
//   reset  in  synchronous reset, active low
//   flush  in  synchronous pipeline flush, active high
//   bus    wb_arbiter_if.slave (producer side and ROB write port)
// Optional build macro WB_BYPASS_EN adds these outputs:
//   bypass_valid, bypass_rob_id, bypass_result
// They show the granted source combinationally in the grant cycle, so that
// issue can forward the result one cycle early.
module wb_arbiter import wb_arbiter_pkg::*; #(
   parameter int N_SRC = N_SRC_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   wb_arbiter_if.slave                bus
`ifdef WB_BYPASS_EN
   ,
   output logic                       bypass_valid,
   output logic [ROB_ENTRY_WIDTH-1:0] bypass_rob_id,
   output logic [WORD_SIZE-1:0]       bypass_result
`endif
);
   localparam int PW = idx_w(N_SRC);

   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    win_idx;
   logic [N_SRC-1:0] arb_grant;
   logic [N_SRC-1:0] grant;
   logic             out_en_q;
   logic             live;
   logic             free;
   wb_entry_t        out_q;
   wb_entry_t        win_entry;

   rr_arbiter #(.N(N_SRC), .IW(PW)) u_rr (
      .req   (bus.src_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (win_idx)
   );

   // The stage can take a new entry when it is empty, or when the ROB consumes
   // the current entry in this cycle. This gives back-to-back writes.
   assign free  = ~out_en_q | bus.rob_ready;
   assign live  = reset & ~flush;
   assign grant = (live & free) ? arb_grant : '0;

   // During flush the producers are flushed too, so nothing is held back.
   assign bus.src_stall = live ? (bus.src_valid & ~grant) : '0;

   assign win_entry.instr_type = bus.src_instr_type[win_idx];
   assign win_entry.pc         = bus.src_pc[win_idx];
   assign win_entry.result     = bus.src_result[win_idx];
   assign win_entry.rob_id     = bus.src_rob_id[win_idx];

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_en_q <= 1'b0;
         out_q    <= '0;
         rr_ptr   <= '0;
      end else if (flush) begin
         out_en_q <= 1'b0;
      end else if (free) begin
         if (|grant) begin
            out_q    <= win_entry;
            out_en_q <= 1'b1;
            rr_ptr   <= (win_idx == PW'(N_SRC-1)) ? '0 : win_idx + 1'b1;
         end else begin
            out_en_q <= 1'b0;
         end
      end
   end

   assign bus.rob_wr_en     = out_en_q;
   assign bus.rob_wr_type   = out_q.instr_type;
   assign bus.rob_wr_pc     = out_q.pc;
   assign bus.rob_wr_result = out_q.result;
   assign bus.rob_wr_id     = out_q.rob_id;

`ifdef WB_BYPASS_EN
   assign bypass_valid  = |grant;
   assign bypass_rob_id = bypass_valid ? win_entry.rob_id : '0;
   assign bypass_result = bypass_valid ? win_entry.result : '0;
`endif
endmodule
